mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_arb2_rr.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/MEM bus arbiter.
package mem_bus_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_e;

  // Owner IDs, also used as the last-grant encoding.
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // A fetch always reads a full word.
  localparam logic [3:0] FETCH_REN = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter_arb2_rr.sv
// Two-input round-robin grant: a lone request wins, a tie goes to the
// requester that did not win last time.
module arb2_rr
  import mem_bus_arbiter_pkg::*;
(
  input  logic en,
  input  logic req_if,
  input  logic req_mem,
  input  logic last_grant,
  output logic gnt_if,
  output logic gnt_mem
);

  // Combinational grant, only while the arbiter can accept a request.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (en) begin
      if (req_if && req_mem) begin
        if (last_grant == OWN_IF) gnt_mem = 1'b1;
        else                      gnt_if  = 1'b1;
      end else begin
        gnt_if  = req_if;
        gnt_mem = req_mem;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch port and a MEM-stage port onto one registered memory
// bus, one transaction at a time, with a read-response watchdog.
//
// Handshake: a requester holds *_req (and its payload) until it sees *_ready,
// which is combinational and only ever high in IDLE; there is no back-pressure
// on the bus side. *_rvalid is a one-cycle pulse to the transaction owner and
// rdata is only meaningful in that cycle (it is 0 otherwise).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  input  logic        mem_req,
  input  logic [3:0]  mem_ren,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        mem_rvalid,
  output logic [31:0] rdata,
  output logic [3:0]  bus_ren,
  output logic [3:0]  bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [3:0]  bus_ren_q, bus_ren_d;
  logic [3:0]  bus_wen_q, bus_wen_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        rsp;
  logic        gnt_if, gnt_mem;

  arb2_rr u_arb (
    .en         (state_q == ST_IDLE),
    .req_if     (if_req),
    .req_mem    (mem_req),
    .last_grant (last_grant_q),
    .gnt_if     (gnt_if),
    .gnt_mem    (gnt_mem)
  );

  assign if_ready   = gnt_if;
  assign mem_ready  = gnt_mem;
  assign if_rvalid  = rsp && (owner_q == OWN_IF);
  assign mem_rvalid = rsp && (owner_q == OWN_MEM);
  assign bus_ren    = bus_ren_q;
  assign bus_wen    = bus_wen_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign dbg_state  = state_q;

  // Next-state, bus load and read-response/watchdog decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    bus_ren_d    = bus_ren_q;
    bus_wen_d    = bus_wen_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    rsp          = 1'b0;
    rdata        = 32'h0;
    timeout_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (gnt_if) begin
          owner_d      = OWN_IF;
          last_grant_d = OWN_IF;
          bus_addr_d   = if_addr;
          bus_wdata_d  = 32'h0;
          bus_ren_d    = FETCH_REN;
          bus_wen_d    = 4'h0;
          state_d      = ST_STROBE;
        end else if (gnt_mem) begin
          owner_d      = OWN_MEM;
          last_grant_d = OWN_MEM;
          bus_addr_d   = mem_addr;
          bus_wdata_d  = mem_wdata;
          bus_ren_d    = mem_ren;
          bus_wen_d    = mem_wen;
          state_d      = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // Strobes live for exactly this one cycle; address/data stay put.
        bus_ren_d = 4'h0;
        bus_wen_d = 4'h0;
        cnt_d     = 8'd0;
        state_d   = (bus_ren_q != 4'h0) ? ST_RD_WAIT : ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (bus_rvalid) begin
          rsp     = 1'b1;
          rdata   = bus_rdata;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog: complete the read with zero data and flag it.
          rsp         = 1'b1;
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bus registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= OWN_IF;
      owner_q      <= OWN_IF;
      bus_ren_q    <= 4'h0;
      bus_wen_q    <= 4'h0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      bus_ren_q    <= bus_ren_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

endmodule
